// File: rtl/fft_uart_framer_if.sv
// Handshake bundles around the spectral-line framer.
//   fft_ctrl_if : spectral-line entry stream from the detector (master) to
//                 the framer (slave), plus the extra byte and the frame-end level.
//   uart_tx_if  : byte stream from the framer (master) to the UART TX (slave).

interface fft_ctrl_if;
    logic [15:0] s_ctrl_addr;
    logic [15:0] s_ctrl_data;
    logic        s_ctrl_valid;
    logic        s_ctrl_ready;
    logic [7:0]  s_ctrl_extra;
    logic        s_ctrl_end;

    modport master (output s_ctrl_addr, s_ctrl_data, s_ctrl_valid, s_ctrl_extra,
                           s_ctrl_end,
                    input  s_ctrl_ready);
    modport slave  (input  s_ctrl_addr, s_ctrl_data, s_ctrl_valid, s_ctrl_extra,
                           s_ctrl_end,
                    output s_ctrl_ready);
endinterface

interface uart_tx_if;
    logic [7:0] m_tx_data;
    logic       m_tx_valid;
    logic       m_tx_ready;

    modport master (output m_tx_data, m_tx_valid, input  m_tx_ready);
    modport slave  (input  m_tx_data, m_tx_valid, output m_tx_ready);
endinterface

// File: rtl/fft_uart_framer.sv
// Byte-level frame packer for detected FFT spectral lines.
// Frame on the wire: HDR0 HDR1 {addr_hi addr_lo data_hi data_lo}* TAIL_MARK
// extra count checksum. Checksum is the 8-bit wrapping sum of every byte
// after HDR1 up to and including the count byte.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   s_ctrl           : entry stream in (addr/data/valid/ready, extra, end level)
//   m_tx             : byte stream out to the UART TX (data/valid/ready)
//   frame_busy       : high from frame start until the checksum byte is taken
//   overrun          : one-cycle pulse when an entry was offered while not ready

module fft_uart_framer #(
    parameter logic [7:0] HDR0       = 8'hAA,
    parameter logic [7:0] HDR1       = 8'h55,
    parameter logic [7:0] TAIL_MARK  = 8'hA5,
    parameter bit         SEND_EMPTY = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    fft_ctrl_if.slave  s_ctrl,
    uart_tx_if.master  m_tx,
    output logic       frame_busy,
    output logic       overrun
);

    typedef enum logic [3:0] {
        IDLE, HDR_A, HDR_B, ENT, OPEN, TAIL_M, TAIL_X, TAIL_C, TAIL_S
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  extra_q, extra_d;
    logic        ent_q, ent_d;        // an entry is latched and not yet sent
    logic [1:0]  idx_q, idx_d;        // byte index within the entry
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic        pend_q, pend_d;      // frame close requested
    logic        end_q, end_d;        // previous frame-end level
    logic        ovr_q, ovr_d;

    logic       tx_valid, ctrl_ready, busy;
    logic [7:0] tx_data;
    logic       tx_fire, accept, end_rise, in_tail, pend_now;

    assign tx_fire  = tx_valid & m_tx.m_tx_ready;
    assign accept   = s_ctrl.s_ctrl_valid & ctrl_ready;
    assign end_rise = s_ctrl.s_ctrl_end & ~end_q;
    assign in_tail  = (state_q == TAIL_M) || (state_q == TAIL_X) ||
                      (state_q == TAIL_C) || (state_q == TAIL_S);
    // A close request arriving on the same edge as the last entry byte must
    // still route the frame to the trailer.
    assign pend_now = pend_q | (end_rise & ~in_tail);

    // State register and datapath registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            extra_q <= '0;
            ent_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            pend_q  <= 1'b0;
            end_q   <= 1'b1;   // a level already high at reset is not a rise
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            extra_q <= extra_d;
            ent_q   <= ent_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            pend_q  <= pend_d;
            end_q   <= end_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (accept || (end_rise && SEND_EMPTY)) state_d = HDR_A;
            HDR_A:  if (tx_fire) state_d = HDR_B;
            HDR_B:  if (tx_fire) state_d = ent_q ? ENT : TAIL_M;
            ENT:    if (tx_fire && idx_q == 2'd3) state_d = pend_now ? TAIL_M : OPEN;
            OPEN: begin
                if (accept)        state_d = ENT;
                else if (end_rise) state_d = TAIL_M;
            end
            TAIL_M: if (tx_fire) state_d = TAIL_X;
            TAIL_X: if (tx_fire) state_d = TAIL_C;
            TAIL_C: if (tx_fire) state_d = TAIL_S;
            TAIL_S: if (tx_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        extra_d = extra_q;
        ent_d   = ent_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        pend_d  = pend_q;
        end_d   = s_ctrl.s_ctrl_end;
        ovr_d   = s_ctrl.s_ctrl_valid & ~ctrl_ready;

        if (accept) begin
            addr_d = s_ctrl.s_ctrl_addr;
            data_d = s_ctrl.s_ctrl_data;
            ent_d  = 1'b1;
        end

        // Close requests are ignored once the trailer is underway; in IDLE
        // without SEND_EMPTY a bare close request opens nothing.
        if (end_rise && !in_tail) begin
            extra_d = s_ctrl.s_ctrl_extra;
            if (!(state_q == IDLE && !SEND_EMPTY && !accept))
                pend_d = 1'b1;
        end

        if (tx_fire) begin
            unique case (state_q)
                ENT: begin
                    sum_d = sum_q + tx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        cnt_d = cnt_q + 8'd1;
                        ent_d = 1'b0;
                    end
                end
                TAIL_M, TAIL_X, TAIL_C: sum_d = sum_q + tx_data;
                TAIL_S: begin
                    cnt_d  = '0;
                    sum_d  = '0;
                    pend_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; every payload source is frozen while its
    // byte is presented, so data stays stable until accepted.
    always_comb begin
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        ctrl_ready = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            IDLE: begin
                ctrl_ready = 1'b1;
                busy       = 1'b0;
            end
            HDR_A: begin tx_valid = 1'b1; tx_data = HDR0; end
            HDR_B: begin tx_valid = 1'b1; tx_data = HDR1; end
            ENT: begin
                tx_valid = 1'b1;
                unique case (idx_q)
                    2'd0: tx_data = addr_q[15:8];
                    2'd1: tx_data = addr_q[7:0];
                    2'd2: tx_data = data_q[15:8];
                    default: tx_data = data_q[7:0];
                endcase
            end
            OPEN:   ctrl_ready = 1'b1;
            TAIL_M: begin tx_valid = 1'b1; tx_data = TAIL_MARK; end
            TAIL_X: begin tx_valid = 1'b1; tx_data = extra_q; end
            TAIL_C: begin tx_valid = 1'b1; tx_data = cnt_q; end
            TAIL_S: begin tx_valid = 1'b1; tx_data = sum_q; end
            default: ;
        endcase
    end

    assign m_tx.m_tx_valid     = tx_valid;
    assign m_tx.m_tx_data      = tx_data;
    assign s_ctrl.s_ctrl_ready = ctrl_ready;
    assign frame_busy          = busy;
    assign overrun             = ovr_q;

endmodule
